jtframe_mailbox: RTL and testbench

Parametrised bidirectional mailbox between a main CPU and a protection/helper MCU. It generalises the single-byte latch-plus-flag handshake (data latch, "byte waiting" IRQ, "reply ready" strobe) to configurable data width and FIFO depth in each direction, with selectable overflow policy, sticky error flags and interrupt outputs for both sides. It sits between the main CPU decode logic and the MCU port logic inside a core's `*_main` module. With `DEPTH=1` and `OVF_MODE=1` it behaves exactly like the legacy latch.

---
 rtl/jtframe_mailbox_pkg.sv | 13 +
 rtl/jtframe_mailbox_fifo.sv | 98 +++++++++
 rtl/jtframe_mailbox.sv | 92 +++++++++
 tb/tb_jtframe_mailbox.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mailbox_pkg.sv
// Shared constants for the CPU/MCU mailbox.
// Overflow policies and status bit positions.
package jtframe_mailbox_pkg;

   localparam int OVF_DROP      = 0;
   localparam int OVF_OVERWRITE = 1;

   localparam int ST_FULL  = 3;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 1;
   localparam int ST_UNF   = 0;

endpackage

// File: rtl/jtframe_mailbox_fifo.sv
// One direction of the mailbox: circular FIFO with
// first-word fall-through head and sticky error flags.
module jtframe_mailbox_fifo
   import jtframe_mailbox_pkg::*;
#(
   parameter int DW       = 8,
   parameter int DEPTH    = 1,
   parameter int OVF_MODE = OVF_OVERWRITE,
   localparam int AW      = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW      = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   input  logic          flush,
   input  logic          ovf_clr,
   input  logic          unf_clr,
   output logic [DW-1:0] head,
   output logic [CW-1:0] cnt,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [DW-1:0] last;
   logic          do_wr, do_ovw, do_pop;
   logic          set_ovf, set_unf;

   // pointers stay at 0 for a single-entry FIFO
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return DEPTH == 1 ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] dec(input logic [AW-1:0] p);
      return DEPTH == 1 ? '0 : p - AW'(1);
   endfunction

   assign full  = cnt == CW'(DEPTH);
   assign empty = cnt == '0;
   assign head  = empty ? last : mem[rd_ptr];

   always_comb begin
      do_pop  = pop & ~empty;
      do_wr   = push & (~full | pop);
      set_ovf = push & full & ~pop;
      do_ovw  = set_ovf & (OVF_MODE == OVF_OVERWRITE);
      set_unf = pop & empty & ~push;
   end

   always_ff @(posedge clk) begin
      if (rst_n && cen && !flush) begin
         if (do_wr)  mem[wr_ptr]      <= din;
         if (do_ovw) mem[dec(wr_ptr)] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         last   <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else if (cen) begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (do_wr)  wr_ptr <= inc(wr_ptr);
            if (do_pop) begin
               rd_ptr <= inc(rd_ptr);
               last   <= mem[rd_ptr];
            end
            if (do_wr && !do_pop)
               cnt <= cnt + CW'(1);
            else if (do_pop && !do_wr)
               cnt <= cnt - CW'(1);
         end
         if (ovf_clr)
            ovf <= 1'b0;
         else if (set_ovf && !flush)
            ovf <= 1'b1;
         if (unf_clr)
            unf <= 1'b0;
         else if (set_unf && !flush)
            unf <= 1'b1;
      end
   end

endmodule

// File: rtl/jtframe_mailbox.sv
// Bidirectional CPU<->MCU mailbox. Each side's clear
// flushes its inbound FIFO and wipes the errors it caused.
module jtframe_mailbox
   import jtframe_mailbox_pkg::*;
#(
   parameter int DW       = 8,
   parameter int DEPTH    = 1,
   parameter int OVF_MODE = OVF_OVERWRITE,
   parameter int HIRQ_EN  = 1,
   localparam int CW      = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          h_wr,
   input  logic [DW-1:0] h_din,
   input  logic          h_rd,
   output logic [DW-1:0] h_dout,
   input  logic          h_clr,
   input  logic          m_wr,
   input  logic [DW-1:0] m_din,
   input  logic          m_rd,
   output logic [DW-1:0] m_dout,
   input  logic          m_clr,
   output logic [CW-1:0] h2m_cnt,
   output logic [CW-1:0] m2h_cnt,
   output logic          m_irq,
   output logic          h_irq,
   output logic [3:0]    h_status,
   output logic [3:0]    m_status
);

   logic h2m_full, h2m_empty, h2m_ovf, h2m_unf;
   logic m2h_full, m2h_empty, m2h_ovf, m2h_unf;

   jtframe_mailbox_fifo #(
      .DW(DW), .DEPTH(DEPTH), .OVF_MODE(OVF_MODE)
   ) u_h2m (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .push    (h_wr),
      .din     (h_din),
      .pop     (m_rd),
      .flush   (m_clr),
      .ovf_clr (h_clr),
      .unf_clr (m_clr),
      .head    (m_dout),
      .cnt     (h2m_cnt),
      .full    (h2m_full),
      .empty   (h2m_empty),
      .ovf     (h2m_ovf),
      .unf     (h2m_unf)
   );

   jtframe_mailbox_fifo #(
      .DW(DW), .DEPTH(DEPTH), .OVF_MODE(OVF_MODE)
   ) u_m2h (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .push    (m_wr),
      .din     (m_din),
      .pop     (h_rd),
      .flush   (h_clr),
      .ovf_clr (m_clr),
      .unf_clr (h_clr),
      .head    (h_dout),
      .cnt     (m2h_cnt),
      .full    (m2h_full),
      .empty   (m2h_empty),
      .ovf     (m2h_ovf),
      .unf     (m2h_unf)
   );

   assign m_irq = ~h2m_empty;
   assign h_irq = (HIRQ_EN != 0) & ~m2h_empty;

   always_comb begin
      h_status           = '0;
      h_status[ST_FULL]  = h2m_full;
      h_status[ST_EMPTY] = m2h_empty;
      h_status[ST_OVF]   = h2m_ovf;
      h_status[ST_UNF]   = m2h_unf;
      m_status           = '0;
      m_status[ST_FULL]  = m2h_full;
      m_status[ST_EMPTY] = h2m_empty;
      m_status[ST_OVF]   = m2h_ovf;
      m_status[ST_UNF]   = h2m_unf;
   end

endmodule

// File: tb/tb_jtframe_mailbox.sv
// Directed bench: three mailbox builds driven by one
// shared set of strobes, each scenario checking one build.
module tb_jtframe_mailbox;

   logic       clk = 1'b0;
   logic       rst_n, cen;
   logic       h_wr, h_rd, h_clr, m_wr, m_rd, m_clr;
   logic [7:0] h_din, m_din;

   logic [7:0] l_hd, l_md, a_hd, a_md, b_hd, b_md;
   logic       l_hc, l_mc;
   logic [2:0] a_hc, a_mc;
   logic [3:0] b_hc, b_mc;
   logic       l_mi, l_hi, a_mi, a_hi, b_mi, b_hi;
   logic [3:0] l_hs, l_ms, a_hs, a_ms, b_hs, b_ms;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jtframe_mailbox #(.DW(8), .DEPTH(1), .OVF_MODE(1), .HIRQ_EN(1)) u_l (
      .clk(clk), .rst_n(rst_n), .cen(cen),
      .h_wr(h_wr), .h_din(h_din), .h_rd(h_rd), .h_dout(l_hd), .h_clr(h_clr),
      .m_wr(m_wr), .m_din(m_din), .m_rd(m_rd), .m_dout(l_md), .m_clr(m_clr),
      .h2m_cnt(l_hc), .m2h_cnt(l_mc), .m_irq(l_mi), .h_irq(l_hi),
      .h_status(l_hs), .m_status(l_ms)
   );

   jtframe_mailbox #(.DW(8), .DEPTH(4), .OVF_MODE(0), .HIRQ_EN(1)) u_a (
      .clk(clk), .rst_n(rst_n), .cen(cen),
      .h_wr(h_wr), .h_din(h_din), .h_rd(h_rd), .h_dout(a_hd), .h_clr(h_clr),
      .m_wr(m_wr), .m_din(m_din), .m_rd(m_rd), .m_dout(a_md), .m_clr(m_clr),
      .h2m_cnt(a_hc), .m2h_cnt(a_mc), .m_irq(a_mi), .h_irq(a_hi),
      .h_status(a_hs), .m_status(a_ms)
   );

   jtframe_mailbox #(.DW(8), .DEPTH(8), .OVF_MODE(0), .HIRQ_EN(1)) u_b (
      .clk(clk), .rst_n(rst_n), .cen(cen),
      .h_wr(h_wr), .h_din(h_din), .h_rd(h_rd), .h_dout(b_hd), .h_clr(h_clr),
      .m_wr(m_wr), .m_din(m_din), .m_rd(m_rd), .m_dout(b_md), .m_clr(m_clr),
      .h2m_cnt(b_hc), .m2h_cnt(b_mc), .m_irq(b_mi), .h_irq(b_hi),
      .h_status(b_hs), .m_status(b_ms)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      h_wr  = 1'b0;
      h_rd  = 1'b0;
      h_clr = 1'b0;
      m_wr  = 1'b0;
      m_rd  = 1'b0;
      m_clr = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      total++;
      if ({l_hd, l_md, a_hd, a_md} !== 32'h0) begin
         bad++;
         $display("FAIL reset_dout got=%h exp=0", {l_hd, l_md, a_hd, a_md});
      end
      total++;
      if ({l_hc, l_mc, a_hc, a_mc, b_hc, b_mc} !== 16'h0) begin
         bad++;
         $display("FAIL reset_cnt got=%h exp=0",
                  {l_hc, l_mc, a_hc, a_mc, b_hc, b_mc});
      end
      total++;
      if ({l_mi, l_hi, a_mi, a_hi} !== 4'h0) begin
         bad++;
         $display("FAIL reset_irq got=%b exp=0000", {l_mi, l_hi, a_mi, a_hi});
      end
      total++;
      if ({l_hs, l_ms, a_hs, a_ms} !== 16'h4444) begin
         bad++;
         $display("FAIL reset_status got=%h exp=4444", {l_hs, l_ms, a_hs, a_ms});
      end
   endtask

   task automatic test_legacy;
      do_reset();
      h_din = 8'h5A; h_wr = 1'b1;
      tick();
      total++;
      if ({l_md, l_mi, l_hc} !== {8'h5A, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL legacy_push got=%h/%b/%b exp=5a/1/1", l_md, l_mi, l_hc);
      end
      h_din = 8'h33; h_wr = 1'b1;
      tick();
      total++;
      if (l_md !== 8'h33) begin
         bad++;
         $display("FAIL legacy_overwrite got=%h exp=33", l_md);
      end
      total++;
      if (l_hs !== 4'b1110) begin
         bad++;
         $display("FAIL legacy_ovf_status got=%b exp=1110", l_hs);
      end
      m_rd = 1'b1;
      tick();
      total++;
      if ({l_mi, l_md, l_ms[2]} !== {1'b0, 8'h33, 1'b1}) begin
         bad++;
         $display("FAIL legacy_pop got=%b/%h/%b exp=0/33/1", l_mi, l_md, l_ms[2]);
      end
      m_din = 8'h21; m_wr = 1'b1;
      tick();
      total++;
      if ({l_hi, l_hd} !== {1'b1, 8'h21}) begin
         bad++;
         $display("FAIL legacy_reply got=%b/%h exp=1/21", l_hi, l_hd);
      end
   endtask

   task automatic test_drop_underflow;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         m_din = 8'(i); m_wr = 1'b1;
         tick();
      end
      total++;
      if ({a_mc, a_ms[3], a_ms[1]} !== {3'd4, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL drop_full got=%0d/%b/%b exp=4/1/1",
                  a_mc, a_ms[3], a_ms[1]);
      end
      total++;
      if (a_hi !== 1'b1) begin
         bad++;
         $display("FAIL drop_hirq got=%b exp=1", a_hi);
      end
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (a_hd !== 8'(i)) begin
            bad++;
            $display("FAIL drop_pop%0d got=%h exp=%h", i, a_hd, 8'(i));
         end
         h_rd = 1'b1;
         tick();
      end
      total++;
      if ({a_hd, a_mc, a_hs[0]} !== {8'h04, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL drop_drained got=%h/%0d/%b exp=04/0/0",
                  a_hd, a_mc, a_hs[0]);
      end
      h_rd = 1'b1;
      tick();
      total++;
      if ({a_hd, a_hs[0], a_hi} !== {8'h04, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL drop_underflow got=%h/%b/%b exp=04/1/0",
                  a_hd, a_hs[0], a_hi);
      end
   endtask

   task automatic test_full_pushpop;
      logic [7:0] exp_q [4];
      exp_q = '{8'h02, 8'h03, 8'h04, 8'h09};
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         h_din = 8'(i); h_wr = 1'b1;
         tick();
      end
      h_din = 8'h09; h_wr = 1'b1; m_rd = 1'b1;
      tick();
      total++;
      if ({a_hc, a_hs[3], a_hs[1]} !== {3'd4, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL full_pushpop got=%0d/%b/%b exp=4/1/0",
                  a_hc, a_hs[3], a_hs[1]);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (a_md !== exp_q[i]) begin
            bad++;
            $display("FAIL full_order%0d got=%h exp=%h", i, a_md, exp_q[i]);
         end
         m_rd = 1'b1;
         tick();
      end
   endtask

   task automatic test_wrap;
      do_reset();
      h_din = 8'd1; h_wr = 1'b1;
      tick();
      for (int k = 2; k <= 21; k++) begin
         total++;
         if (b_md !== 8'(k - 1)) begin
            bad++;
            $display("FAIL wrap_data%0d got=%h exp=%h", k, b_md, 8'(k - 1));
         end
         h_din = 8'(k); h_wr = 1'b1; m_rd = 1'b1;
         tick();
         total++;
         if (b_hc !== 4'd1) begin
            bad++;
            $display("FAIL wrap_cnt%0d got=%0d exp=1", k, b_hc);
         end
      end
      total++;
      if (b_md !== 8'd21) begin
         bad++;
         $display("FAIL wrap_last got=%h exp=15", b_md);
      end
   endtask

   task automatic test_flush;
      do_reset();
      m_rd = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         m_din = 8'hA0; m_wr = 1'b1;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         h_din = 8'(8'h10 + i); h_wr = 1'b1;
         tick();
      end
      total++;
      if ({a_hc, a_ms[1:0]} !== {3'd3, 2'b11}) begin
         bad++;
         $display("FAIL flush_setup got=%0d/%b exp=3/11", a_hc, a_ms[1:0]);
      end
      cen = 1'b0; m_clr = 1'b1; h_wr = 1'b1;
      tick();
      cen = 1'b1;
      total++;
      if ({a_hc, a_ms[1:0], a_md} !== {3'd3, 2'b11, 8'h10}) begin
         bad++;
         $display("FAIL flush_cen_low got=%0d/%b/%h exp=3/11/10",
                  a_hc, a_ms[1:0], a_md);
      end
      m_clr = 1'b1; h_din = 8'hEE; h_wr = 1'b1;
      tick();
      total++;
      if ({a_hc, a_mi, a_ms[2:0]} !== {3'd0, 1'b0, 3'b100}) begin
         bad++;
         $display("FAIL flush_h2m got=%0d/%b/%b exp=0/0/100",
                  a_hc, a_mi, a_ms[2:0]);
      end
      total++;
      if (a_mc !== 3'd4) begin
         bad++;
         $display("FAIL flush_other_dir got=%0d exp=4", a_mc);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      h_din = 8'h41; h_wr = 1'b1; m_din = 8'h42; m_wr = 1'b1;
      tick();
      h_din = 8'h43; h_wr = 1'b1; m_din = 8'h44; m_wr = 1'b1;
      tick();
      total++;
      if ({a_hc, a_mc} !== {3'd2, 3'd2}) begin
         bad++;
         $display("FAIL mid_setup got=%0d/%0d exp=2/2", a_hc, a_mc);
      end
      rst_n = 1'b0; h_wr = 1'b1; m_wr = 1'b1;
      tick();
      rst_n = 1'b1;
      total++;
      if ({a_hc, a_mc, a_mi, a_hi, a_hd, a_md} !== 24'h0) begin
         bad++;
         $display("FAIL mid_reset got=%h exp=0",
                  {a_hc, a_mc, a_mi, a_hi, a_hd, a_md});
      end
      total++;
      if ({a_hs, a_ms} !== 8'h44) begin
         bad++;
         $display("FAIL mid_status got=%h exp=44", {a_hs, a_ms});
      end
      h_din = 8'h77; h_wr = 1'b1;
      tick();
      total++;
      if ({a_hc, a_md, a_mi} !== {3'd1, 8'h77, 1'b1}) begin
         bad++;
         $display("FAIL mid_after got=%0d/%h/%b exp=1/77/1", a_hc, a_md, a_mi);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cen   = 1'b1;
      h_wr  = 1'b0;
      h_rd  = 1'b0;
      h_clr = 1'b0;
      m_wr  = 1'b0;
      m_rd  = 1'b0;
      m_clr = 1'b0;
      h_din = '0;
      m_din = '0;
      #2;
      test_reset();
      test_legacy();
      test_drop_underflow();
      test_full_pushpop();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
